// File: rtl/branch_ctrl_pkg.sv
// Shared definitions for the EX-stage branch resolution controller:
// RV32I branch funct3 encodings and the redirect FSM state type.
package branch_ctrl_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_REDIRECT = 1'b1
  } br_state_t;

endpackage

// File: rtl/branch_ctrl_cond.sv
// Combinational branch condition evaluation: funct3 + comparator flags
// to taken / reserved-encoding indication.
module branch_ctrl_cond
  import branch_ctrl_pkg::*;
(
  input  logic [2:0] i_funct3,
  input  logic       i_eq,
  input  logic       i_lt,
  output logic       o_taken,
  output logic       o_illegal
);

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    o_taken   = 1'b0;
    o_illegal = 1'b0;
    unique case (i_funct3)
      F3_BEQ:           o_taken = i_eq;
      F3_BNE:           o_taken = !i_eq;
      F3_BLT, F3_BLTU:  o_taken = i_lt;
      F3_BGE, F3_BGEU:  o_taken = !i_lt;
      default:          o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_ctrl.sv
// EX-stage branch/jump resolution: static predict-not-taken, one-cycle
// registered redirect with squash of wrong-path stages, and branch counters.
module branch_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic             ex_is_branch,
  input  logic             ex_is_jump,
  input  logic [2:0]       ex_funct3,
  input  logic [XLEN-1:0]  ex_target,
  input  logic             stall,
  input  logic             eq,
  input  logic             lt,
  output logic             br_un,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             kill_ex,
  output logic             illegal_br,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] taken_count
);

  br_state_t        r_state;
  logic             r_redirect_valid;
  logic [XLEN-1:0]  r_redirect_pc;
  logic             r_flush_if_id;
  logic             r_flush_id_ex;
  logic             r_kill_ex;
  logic             r_illegal_br;
  logic [CNT_W-1:0] r_br_count;
  logic [CNT_W-1:0] r_taken_count;

  logic w_cond_taken;
  logic w_cond_illegal;
  logic w_resolve;
  logic w_is_cond;
  logic w_taken;

  branch_ctrl_cond u_cond (
    .i_funct3  (ex_funct3),
    .i_eq      (eq),
    .i_lt      (lt),
    .o_taken   (w_cond_taken),
    .o_illegal (w_cond_illegal)
  );

  assign br_un = ex_funct3[1];

  // kill_ex is high exactly in REDIRECT, so it also blocks wrong-path resolution.
  assign w_resolve = ex_valid && !stall && !r_kill_ex && (ex_is_branch || ex_is_jump);
  assign w_is_cond = ex_is_branch && !ex_is_jump;
  assign w_taken   = ex_is_jump || (w_is_cond && w_cond_taken);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      r_state          <= ST_RUN;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
      r_flush_if_id    <= 1'b0;
      r_flush_id_ex    <= 1'b0;
      r_kill_ex        <= 1'b0;
      r_illegal_br     <= 1'b0;
    end else begin
      r_redirect_valid <= 1'b0;
      r_flush_if_id    <= 1'b0;
      r_flush_id_ex    <= 1'b0;
      r_kill_ex        <= 1'b0;
      r_illegal_br     <= w_resolve && w_is_cond && w_cond_illegal;
      unique case (r_state)
        ST_RUN: begin
          if (w_resolve && w_taken) begin
            r_state          <= ST_REDIRECT;
            r_redirect_pc    <= ex_target;
            r_redirect_valid <= 1'b1;
            r_flush_if_id    <= 1'b1;
            r_flush_id_ex    <= 1'b1;
            r_kill_ex        <= 1'b1;
          end
        end
        ST_REDIRECT: r_state <= ST_RUN;
        default:     r_state <= ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_br_count    <= '0;
      r_taken_count <= '0;
    end else begin
      if (w_resolve && w_is_cond) r_br_count    <= r_br_count + CNT_W'(1);
      if (w_resolve && w_taken)   r_taken_count <= r_taken_count + CNT_W'(1);
    end
  end

  assign redirect_valid = r_redirect_valid;
  assign redirect_pc    = r_redirect_pc;
  assign flush_if_id    = r_flush_if_id;
  assign flush_id_ex    = r_flush_id_ex;
  assign kill_ex        = r_kill_ex;
  assign illegal_br     = r_illegal_br;
  assign br_count       = r_br_count;
  assign taken_count    = r_taken_count;

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed self-checking bench for branch_ctrl; expected values are
// hand-computed per step.
module tb_branch_ctrl;

  localparam int XLEN  = 32;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             ex_valid;
  logic             ex_is_branch;
  logic             ex_is_jump;
  logic [2:0]       ex_funct3;
  logic [XLEN-1:0]  ex_target;
  logic             stall;
  logic             eq;
  logic             lt;
  logic             br_un;
  logic             redirect_valid;
  logic [XLEN-1:0]  redirect_pc;
  logic             flush_if_id;
  logic             flush_id_ex;
  logic             kill_ex;
  logic             illegal_br;
  logic [CNT_W-1:0] br_count;
  logic [CNT_W-1:0] taken_count;

  int total = 0;
  int bad   = 0;

  branch_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .ex_valid       (ex_valid),
    .ex_is_branch   (ex_is_branch),
    .ex_is_jump     (ex_is_jump),
    .ex_funct3      (ex_funct3),
    .ex_target      (ex_target),
    .stall          (stall),
    .eq             (eq),
    .lt             (lt),
    .br_un          (br_un),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .flush_if_id    (flush_if_id),
    .flush_id_ex    (flush_id_ex),
    .kill_ex        (kill_ex),
    .illegal_br     (illegal_br),
    .br_count       (br_count),
    .taken_count    (taken_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change #1 after an edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Redirect group (valid, both flushes, kill) must all move together.
  task automatic expect_outs(input string tag, input logic exp_redir, input logic [31:0] exp_pc,
                             input logic exp_ill, input logic [31:0] exp_br, input logic [31:0] exp_tk);
    check({tag, ".redirect_valid"}, 32'(redirect_valid), 32'(exp_redir));
    check({tag, ".flush_if_id"},    32'(flush_if_id),    32'(exp_redir));
    check({tag, ".flush_id_ex"},    32'(flush_id_ex),    32'(exp_redir));
    check({tag, ".kill_ex"},        32'(kill_ex),        32'(exp_redir));
    if (exp_redir) check({tag, ".redirect_pc"}, redirect_pc, exp_pc);
    check({tag, ".illegal_br"},     32'(illegal_br),     32'(exp_ill));
    check({tag, ".br_count"},       br_count,            exp_br);
    check({tag, ".taken_count"},    taken_count,         exp_tk);
  endtask

  task automatic set_br(input logic br, input logic jmp, input logic [2:0] f3,
                        input logic e, input logic l, input logic [31:0] tgt);
    ex_valid     = 1'b1;
    ex_is_branch = br;
    ex_is_jump   = jmp;
    ex_funct3    = f3;
    eq           = e;
    lt           = l;
    ex_target    = tgt;
  endtask

  initial begin
    rst = 1'b1; ex_valid = 1'b0; ex_is_branch = 1'b0; ex_is_jump = 1'b0;
    ex_funct3 = 3'b000; ex_target = '0; stall = 1'b0; eq = 1'b0; lt = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    expect_outs("reset", 1'b0, 32'h0, 1'b0, 32'd0, 32'd0);
    check("reset.redirect_pc", redirect_pc, 32'h0);

    // br_un follows funct3[1] combinationally, regardless of valid.
    ex_funct3 = 3'b110; #1;
    check("br_un.f3_110", 32'(br_un), 32'd1);
    ex_funct3 = 3'b101; #1;
    check("br_un.f3_101", 32'(br_un), 32'd0);

    // Taken BEQ -> redirect at N+1, clear at N+2.
    set_br(1'b1, 1'b0, 3'b000, 1'b1, 1'b0, 32'h0000_0100);
    tick();
    expect_outs("beq.n1", 1'b1, 32'h100, 1'b0, 32'd1, 32'd1);
    ex_valid = 1'b0;
    tick();
    expect_outs("beq.n2", 1'b0, 32'h0, 1'b0, 32'd1, 32'd1);

    // Not-taken BLTU.
    set_br(1'b1, 1'b0, 3'b110, 1'b0, 1'b0, 32'h0000_0180); #1;
    check("bltu.br_un", 32'(br_un), 32'd1);
    tick();
    expect_outs("bltu.nt", 1'b0, 32'h0, 1'b0, 32'd2, 32'd1);
    ex_valid = 1'b0;

    // Taken BNE held by a 3-cycle stall resolves once after release.
    set_br(1'b1, 1'b0, 3'b001, 1'b0, 1'b0, 32'h0000_0200);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_outs($sformatf("bne.stall%0d", i), 1'b0, 32'h0, 1'b0, 32'd2, 32'd1);
    end
    stall = 1'b0;
    tick();
    expect_outs("bne.release", 1'b1, 32'h200, 1'b0, 32'd3, 32'd2);
    ex_valid = 1'b0;
    tick();
    expect_outs("bne.after", 1'b0, 32'h0, 1'b0, 32'd3, 32'd2);

    // JAL, then a taken-looking branch in EX during REDIRECT is ignored.
    set_br(1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 32'h0000_0400);
    tick();
    expect_outs("jal.n1", 1'b1, 32'h400, 1'b0, 32'd3, 32'd3);
    set_br(1'b1, 1'b0, 3'b000, 1'b1, 1'b0, 32'h0000_0800);
    tick();
    expect_outs("jal.wrongpath", 1'b0, 32'h0, 1'b0, 32'd3, 32'd3);
    ex_valid = 1'b0;
    tick();
    expect_outs("jal.idle", 1'b0, 32'h0, 1'b0, 32'd3, 32'd3);

    // Reserved funct3=011: one illegal pulse, counted, no redirect.
    set_br(1'b1, 1'b0, 3'b011, 1'b1, 1'b1, 32'h0000_0900);
    tick();
    expect_outs("illegal.n1", 1'b0, 32'h0, 1'b1, 32'd4, 32'd3);
    ex_valid = 1'b0;
    tick();
    expect_outs("illegal.n2", 1'b0, 32'h0, 1'b0, 32'd4, 32'd3);

    // Taken BGEU (lt=0).
    set_br(1'b1, 1'b0, 3'b111, 1'b0, 1'b0, 32'h0000_0a00);
    tick();
    expect_outs("bgeu.n1", 1'b1, 32'ha00, 1'b0, 32'd5, 32'd4);
    ex_valid = 1'b0;
    tick();

    // Branch+jump with reserved funct3 behaves as a jump; reset in REDIRECT.
    set_br(1'b1, 1'b1, 3'b010, 1'b0, 1'b0, 32'h0000_0c00);
    tick();
    expect_outs("bj.n1", 1'b1, 32'hc00, 1'b0, 32'd5, 32'd5);
    ex_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expect_outs("rst_redirect", 1'b0, 32'h0, 1'b0, 32'd0, 32'd0);
    check("rst_redirect.redirect_pc", redirect_pc, 32'h0);

    // FSM back in RUN: a taken BLT redirects normally.
    set_br(1'b1, 1'b0, 3'b100, 1'b0, 1'b1, 32'h0000_0d00);
    tick();
    expect_outs("blt.post_rst", 1'b1, 32'hd00, 1'b0, 32'd1, 32'd1);
    ex_valid = 1'b0;
    tick();
    expect_outs("blt.after", 1'b0, 32'h0, 1'b0, 32'd1, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_ctrl.md
Name: branch_ctrl

Overview:
- EX-stage branch/jump resolution controller for the 5-stage RV32I pipeline.
- Drives the branch comparator's unsigned-select and evaluates its Eq/Lt results against funct3.
- Static predict-not-taken; on taken branch or jump, issues a registered PC redirect and squashes wrong-path instructions.
- Sits between ID/EX pipeline register, hazard unit (stall) and fetch PC mux; keeps branch performance counters.

Parameters:
- XLEN, 32, address/data width.
- CNT_W, 32, width of performance counters (wrap-around).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- ex_valid  input  1  EX stage holds a valid instruction
- ex_is_branch  input  1  EX instruction is conditional branch (opcode 1100011)
- ex_is_jump  input  1  EX instruction is JAL or JALR
- ex_funct3  input  3  funct3 of EX instruction
- ex_target  input  XLEN  computed branch/jump target (JALR LSB already cleared upstream)
- stall  input  1  hazard-unit stall; EX instruction held
- eq  input  1  comparator equal result
- lt  input  1  comparator less-than result
- br_un  output  1  comparator unsigned select (combinational)
- redirect_valid  output  1  load redirect_pc into fetch PC
- redirect_pc  output  XLEN  redirect target
- flush_if_id  output  1  clear IF/ID register
- flush_id_ex  output  1  clear ID/EX register
- kill_ex  output  1  instruction currently in EX is wrong-path; suppress its writeback/memory effects
- illegal_br  output  1  one-cycle pulse: branch with reserved funct3 (010/011)
- br_count  output  CNT_W  resolved conditional branches
- taken_count  output  CNT_W  taken conditional branches plus jumps

Behaviour:
- Reset (rst=1 at clk edge): state=RUN; redirect_valid, flush_if_id, flush_id_ex, kill_ex, illegal_br=0; redirect_pc=0; both counters=0. Reset overrides any pending redirect.
- br_un = ex_funct3[1] (1 for BLTU/BGEU), combinational, independent of valid/state.
- Condition: 000 BEQ eq; 001 BNE !eq; 100/110 lt; 101/111 !lt; 010/011 not taken and flags illegal_br.
- resolve = ex_valid & !stall & !kill_ex & (ex_is_branch | ex_is_jump). Jump always taken.
- States: RUN, REDIRECT.
- RUN: if resolve & taken -> REDIRECT at next edge, registering redirect_pc=ex_target. Otherwise stay RUN.
- REDIRECT (exactly one cycle): redirect_valid=1, flush_if_id=1, flush_id_ex=1, kill_ex=1 (instruction that entered EX behind the branch). Next state RUN unconditionally; stall has no effect on REDIRECT.
- Latency: taken decision in cycle N -> redirect/flush asserted cycle N+1 -> correct-path fetch in cycle N+1, correct instruction reaches EX in N+3.
- Any branch/jump in EX during REDIRECT is wrong-path: ignored, not counted.
- Stall: no resolution or counting while stall=1; held branch resolves once, in the first cycle stall=0.
- illegal_br: registered pulse in cycle N+1 when resolve & ex_is_branch & funct3 in {010,011}; counts in br_count, no redirect.
- Counters: br_count +1 per resolved conditional branch; taken_count +1 per taken branch or resolved jump; wrap at 2^CNT_W.
- ex_is_branch and ex_is_jump both high: treated as jump.
- Not-taken branch: no redirect, no flush; pipeline continues.

Decomposition:
- Shared package: funct3 constants (F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU), state enum type br_state_t.
- Optional sub-module br_cond_eval: combinational funct3/eq/lt to taken/illegal. The FSM and counters stay in branch_ctrl.

Test Plan:
- BEQ, funct3=000, eq=1, target=0x0000_0100 -> cycle N+1: redirect_valid=1, redirect_pc=0x100, all flushes/kill=1; N+2 all 0; br_count=1, taken_count=1.
- BLTU, funct3=110, lt=0 -> br_un=1, no redirect; br_count increments, taken_count unchanged.
- Taken BNE with stall=1 for 3 cycles -> no redirect while stalled; single redirect the cycle after stall drops; br_count +1 exactly once.
- JAL followed by back-to-back branch in EX during REDIRECT -> wrong-path branch ignored; counts show only the jump (taken_count=1, br_count=0).
- funct3=011 branch -> illegal_br pulses once at N+1, no redirect, br_count=1.
- rst asserted in REDIRECT cycle -> next cycle all outputs 0, state RUN, counters 0.
